// File: rtl/modinv_if.sv
// modinv_if: valid/ready bus around the modinv block.
// master = operand source / result sink; slave = modinv. err only with MODINV_ERR_EN.
interface modinv_if #(
  parameter int W = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] m;
`ifdef MODINV_ERR_EN
  logic         err;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, m, err
  );
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, m, err
  );
`else
  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, m
  );
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, m
  );
`endif
endinterface

// File: rtl/modinv.sv
// modinv: sequential modular inverse m = a^(P-2) mod P, square-and-multiply, one product/cycle.
// Ports: clk, reset (sync, active-low), bus (modinv_if.slave). Option macro: MODINV_ERR_EN (err port).
module modinv #(
  parameter int W = 5,
  parameter int P = 29
) (
  input  logic       clk,
  input  logic       reset,
  modinv_if.slave    bus
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]   E  = W'(P - 2);
  localparam logic [2*W-1:0] PW = (2*W)'(P);

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t        st;
  logic [W-1:0]  acc;
  logic [W-1:0]  a_r;
  logic [IW-1:0] i;
  logic [W-1:0]  m_r;
  logic          ov;

  logic [2*W-1:0] acc_x;
  logic [2*W-1:0] ar_x;
  logic [2*W-1:0] in_x;
  logic [W-1:0]   sq;
  logic [W-1:0]   mu;
  logic [W-1:0]   a_red;

  function automatic logic [W-1:0] modp(
    input logic [2*W-1:0] x
  );
    return W'(x % PW);
  endfunction

  always_comb begin
    acc_x = {{W{1'b0}}, acc};
    ar_x  = {{W{1'b0}}, a_r};
    in_x  = {{W{1'b0}}, bus.a};
    sq    = modp(acc_x * acc_x);
    mu    = modp(acc_x * ar_x);
    a_red = modp(in_x);
  end

  assign bus.in_ready  = (st == IDLE) && reset;
  assign bus.out_valid = ov;
  assign bus.m         = m_r;

`ifdef MODINV_ERR_EN
  logic err_r;
  assign bus.err = err_r;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      st  <= IDLE;
      acc <= W'(1);
      a_r <= '0;
      i   <= '0;
      m_r <= '0;
      ov  <= 1'b0;
`ifdef MODINV_ERR_EN
      err_r <= 1'b0;
`endif
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            a_r <= a_red;
            acc <= W'(1);
            i   <= IW'(W - 1);
            st  <= SQR;
          end
        end
        SQR: begin
          acc <= sq;
          if (E[i]) begin
            st <= MUL;
          end else if (i != '0) begin
            i <= i - 1'b1;
          end else begin
            st  <= DONE;
            ov  <= 1'b1;
            m_r <= sq;
`ifdef MODINV_ERR_EN
            err_r <= (a_r == '0);
`endif
          end
        end
        MUL: begin
          acc <= mu;
          if (i != '0) begin
            i  <= i - 1'b1;
            st <= SQR;
          end else begin
            st  <= DONE;
            ov  <= 1'b1;
            m_r <= mu;
`ifdef MODINV_ERR_EN
            err_r <= (a_r == '0);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            st <= IDLE;
            ov <= 1'b0;
`ifdef MODINV_ERR_EN
            err_r <= 1'b0;
`endif
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modinv.sv
// tb_modinv: randomized + directed scoreboard bench for modinv.
// Reference inverse computed as repeated multiplication a^(P-2) mod P.
module tb_modinv;

  localparam int W = 5;
  localparam int P = 29;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  modinv_if #(.W(W)) bus();

  modinv #(.W(W), .P(P)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int a;
    int m;
    bit err;
    int acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int or_mode = 1;
  bit bb = 1'b0;
  int last_acc = -1;
  bit pv = 1'b0;
  bit stalled = 1'b0;
  int held_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (or_mode == 2) bus.out_ready = ($urandom_range(0, 3) != 0);
    else bus.out_ready = (or_mode == 1);
  end

  function automatic int ref_inv(input int a);
    int ar;
    int r;
    ar = a % P;
    r = 1;
    for (int k = 0; k < P - 2; k++) r = (r * ar) % P;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send(input int a);
    int t;
    exp_t e;
    @(negedge clk);
    bus.a = W'(a);
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.a = a;
      e.m = ref_inv(a);
      e.err = ((a % P) == 0);
      e.acc = cyc + 1;
      if (bb && last_acc >= 0) chk("throughput", e.acc - last_acc, 11);
      last_acc = e.acc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_m"}, int'(bus.m), 0);
`ifdef MODINV_ERR_EN
    chk({tag, "_err"}, int'(bus.err), 0);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.out_valid) begin
        chk("in_ready_busy", int'(bus.in_ready), 0);
        if (!pv) begin
          if (q.size() == 0) chk("spurious_valid", 1, 0);
          else chk("latency", cyc - q[0].acc, 9);
        end else if (stalled) begin
          chk("hold_m", int'(bus.m), held_m);
        end
        if (bus.out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("m", int'(bus.m), e.m);
          if ((e.a % P) != 0)
            chk("a_times_m", ((e.a % P) * int'(bus.m)) % P, 1);
`ifdef MODINV_ERR_EN
          chk("err", int'(bus.err), int'(e.err));
`endif
        end
        stalled = !bus.out_ready;
        held_m = int'(bus.m);
      end
      pv = bus.out_valid;
    end else begin
      pv = 1'b0;
      stalled = 1'b0;
    end
  end

  initial begin
    int dir[7];
    int t;
    dir = '{2, 3, 28, 1, 31, 29, 0};
    bus.in_valid = 1'b0;
    bus.a = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    bb = 1'b1;
    foreach (dir[k]) send(dir[k]);
    for (int a = 1; a < P; a++) send(a);
    drain();
    bb = 1'b0;

    or_mode = 0;
    send(5);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", int'(bus.out_valid), 1);
    repeat (6) @(negedge clk);
    chk("stall_still_valid", int'(bus.out_valid), 1);
    or_mode = 1;
    drain();

    send(2);
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    chk_reset_state("abort");
    @(posedge clk);
    #1 reset = 1'b1;
    send(3);
    drain();

    or_mode = 2;
    for (int k = 0; k < 40; k++) send(int'($urandom_range(0, 31)));
    drain();
    or_mode = 1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
